rx_bit_unstuffer: RTL and testbench
===================================

Name: rx_bit_unstuffer

Overview:
Receive-path stage directly downstream of the NRZI decoder. It consumes one decoded bit per bit strobe and removes USB stuffed bits (the 0 inserted after six consecutive 1s). It flags stuffing violations and assembles the surviving data bits LSB-first into bytes for the packet layer. SYNC is treated as ordinary data, so the first byte of a clean packet is 0x80.

Parameters:
STUFF_LIMIT, 6, number of consecutive 1s after which the next bit is a stuff bit
BYTE_W, 8, width of the assembled output word

Ports:
clk  input  1  system clock
nRST  input  1  asynchronous active-low reset
bit_valid  input  1  decoded_bit is valid this cycle (one-cycle strobe per USB bit)
decoded_bit  input  1  bit from the NRZI decoder
packet_active  input  1  high from first SYNC bit until EOP is detected upstream
byte_out  output  BYTE_W  last assembled byte; holds its value until the next byte completes
byte_valid  output  1  one-cycle pulse; byte_out is new this cycle
stuff_err  output  1  one-cycle pulse on a stuffing violation
align_err  output  1  one-cycle pulse when a packet ends with a partial byte

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE; ones_cnt=0; bit_cnt=0; shift register=0.
  - byte_out=0; byte_valid=0; stuff_err=0; align_err=0.
  - Reset mid-packet abandons the packet; no error pulses are produced.
- FSM states: IDLE, RECEIVE, ERROR.
  - IDLE -> RECEIVE when packet_active=1. On this transition ones_cnt, bit_cnt and the shift register are cleared.
  - A bit_valid in the same cycle as that transition is processed as the first bit.
  - RECEIVE -> ERROR on a stuff violation.
  - RECEIVE -> IDLE when packet_active=0.
  - ERROR -> IDLE when packet_active=0.
- RECEIVE, on bit_valid=1 with packet_active=1:
  - ones_cnt==STUFF_LIMIT and bit=0: stuff bit. Drop it and clear ones_cnt; bit_cnt and the shift register are unchanged.
  - ones_cnt==STUFF_LIMIT and bit=1: violation. Pulse stuff_err the next cycle and go to ERROR; no byte is emitted for the partial byte.
  - Otherwise (data bit):
    - Shift right with the new bit entering the MSB, so the first received bit ends in bit 0.
    - ones_cnt increments if bit=1 and clears if bit=0.
    - bit_cnt increments modulo BYTE_W.
  - When the data bit is the BYTE_W-th of its byte, byte_out loads the completed word and byte_valid pulses. Both are registered: the pulse comes 1 cycle after the accepting edge.
- ERROR: all bits are ignored and no outputs pulse until packet_active falls.
- packet_active falling in RECEIVE with bit_cnt!=0: align_err pulses one cycle later.
- A bit_valid coincident with packet_active=0 is ignored in all states.
- A stuff bit never counts toward bit_cnt. A stuff bit landing exactly on a byte boundary does not delay that byte's byte_valid.
- ones_cnt saturates logically at STUFF_LIMIT and is 3 bits wide for the default value ($clog2(STUFF_LIMIT+1)).
- Outputs are fully registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package usb_rx_pkg holds:
  - rx_unstuff_state_t enum (IDLE, RECEIVE, ERROR);
  - USB_STUFF_LIMIT=6;
  - USB_SYNC_BYTE=8'h80.
- One natural sub-module: usb_ones_counter (consecutive-ones count plus is_stuff_slot flag). It is reusable by the transmit-side bit stuffer.
- Byte assembly and the FSM stay in this module.

Test Plan:
- Clean packet: bits 0,0,0,0,0,0,0,1 (SYNC) then 1,0,1,0,0,1,0,1, then packet_active drops -> byte_valid twice with byte_out=0x80 then 0xA5; no errors.
- Stuffing: data 0xFF,0xFF sent as eight 1s with a 0 after the 6th 1, and again after each further 6 ones -> stuff bits dropped; byte_out=0xFF twice; stuff_err=0.
- Violation: seven consecutive 1s -> stuff_err pulses once 1 cycle after the 7th bit; no further byte_valid until packet_active falls; the next packet decodes normally.
- Partial byte: SYNC followed by 3 data bits, then packet_active=0 -> one byte_valid (0x80) and one align_err pulse.
- Boundary stuff: a byte ending in six 1s followed by a stuff 0 -> byte_valid asserted for that byte before the stuff bit; the next byte is unaffected.
- Reset mid-packet: assert nRST=0 after 4 data bits -> all outputs 0 immediately; after release the next packet's first byte is 0x80.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive path
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        ERROR
    } rx_unstuff_state_t;

    localparam int USB_STUFF_LIMIT = 6;
    localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

endpackage

// File: rtl/rx_bit_unstuffer_if.sv
// rtl/rx_bit_unstuffer_if.sv - decoded-bit input and assembled-byte output bundle
interface rx_bit_unstuffer_if #(
    parameter int BYTE_W = 8
);
    logic              bit_valid;
    logic              decoded_bit;
    logic              packet_active;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              stuff_err;
    logic              align_err;

    modport master (
        output bit_valid, decoded_bit, packet_active,
        input  byte_out, byte_valid, stuff_err, align_err
    );

    modport slave (
        input  bit_valid, decoded_bit, packet_active,
        output byte_out, byte_valid, stuff_err, align_err
    );
endinterface

// File: rtl/usb_ones_counter.sv
// rtl/usb_ones_counter.sv - consecutive-ones tracker flagging the bit-stuff slot
module usb_ones_counter
    import usb_rx_pkg::*;
#(
    parameter int LIMIT = USB_STUFF_LIMIT
) (
    input  logic clk,
    input  logic nRST,
    input  logic clear,
    input  logic advance,
    input  logic bit_in,
    output logic is_stuff_slot
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_CNT = CW'(LIMIT);

    logic [CW-1:0] count;
    logic [CW-1:0] base;
    logic [CW-1:0] count_d;

    // clear and advance may coincide: the bit is then counted from zero
    always_comb begin
        base    = clear ? '0 : count;
        count_d = base;
        if (advance) begin
            if (!bit_in) begin
                count_d = '0;
            end else if (base != LIMIT_CNT) begin
                count_d = base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    assign is_stuff_slot = (count == LIMIT_CNT);

endmodule

// File: rtl/rx_bit_unstuffer.sv
// rtl/rx_bit_unstuffer.sv - drops USB stuffed bits and assembles LSB-first bytes
module rx_bit_unstuffer
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LIMIT = USB_STUFF_LIMIT,
    parameter int BYTE_W      = 8
) (
    input  logic                 clk,
    input  logic                 nRST,
    rx_bit_unstuffer_if.slave    bus
);
    localparam int BCW = $clog2(BYTE_W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(BYTE_W - 1);

    rx_unstuff_state_t state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d, shift_base, shift_next;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d, bit_cnt_base;
    logic [BYTE_W-1:0] byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              stuff_err_q, stuff_err_d;
    logic              align_err_q, align_err_d;
    logic              cnt_clear, cnt_advance, take_data, is_stuff_slot;

    usb_ones_counter #(.LIMIT(STUFF_LIMIT)) u_ones (
        .clk           (clk),
        .nRST          (nRST),
        .clear         (cnt_clear),
        .advance       (cnt_advance),
        .bit_in        (bus.decoded_bit),
        .is_stuff_slot (is_stuff_slot)
    );

    always_comb begin
        state_d      = state_q;
        shift_base   = shift_q;
        bit_cnt_base = bit_cnt_q;
        shift_d      = shift_q;
        shift_next   = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        stuff_err_d  = 1'b0;
        align_err_d  = 1'b0;
        cnt_clear    = 1'b0;
        cnt_advance  = 1'b0;
        take_data    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.packet_active) begin
                    state_d      = RECEIVE;
                    cnt_clear    = 1'b1;
                    shift_base   = '0;
                    bit_cnt_base = '0;
                    shift_d      = '0;
                    bit_cnt_d    = '0;
                    take_data    = bus.bit_valid;
                end
            end
            RECEIVE: begin
                if (!bus.packet_active) begin
                    state_d     = IDLE;
                    align_err_d = (bit_cnt_q != '0);
                end else if (bus.bit_valid) begin
                    if (!is_stuff_slot) begin
                        take_data = 1'b1;
                    end else if (!bus.decoded_bit) begin
                        cnt_advance = 1'b1;
                    end else begin
                        stuff_err_d = 1'b1;
                        state_d     = ERROR;
                    end
                end
            end
            ERROR: begin
                if (!bus.packet_active) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // first received bit drifts down to bit 0 after BYTE_W shifts
        if (take_data) begin
            cnt_advance = 1'b1;
            shift_next  = {bus.decoded_bit, shift_base[BYTE_W-1:1]};
            shift_d     = shift_next;
            if (bit_cnt_base == LAST_BIT) begin
                bit_cnt_d    = '0;
                byte_out_d   = shift_next;
                byte_valid_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            stuff_err_q  <= stuff_err_d;
            align_err_q  <= align_err_d;
        end
    end

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.stuff_err  = stuff_err_q;
    assign bus.align_err  = align_err_q;

endmodule

// File: tb/tb_rx_bit_unstuffer.sv
// tb/tb_rx_bit_unstuffer.sv - directed self-checking bench for rx_bit_unstuffer
module tb_rx_bit_unstuffer;
    import usb_rx_pkg::*;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    rx_bit_unstuffer_if #(.BYTE_W(8)) bus ();

    rx_bit_unstuffer #(.STUFF_LIMIT(6), .BYTE_W(8)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] bytes[$];
    int stuff_cnt = 0;
    int align_cnt = 0;
    bit seq[$];

    always @(negedge clk) begin
        if (bus.byte_valid) bytes.push_back(bus.byte_out);
        if (bus.stuff_err) stuff_cnt++;
        if (bus.align_err) align_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        if (i < bytes.size()) return bytes[i];
        return 8'hxx;
    endfunction

    task automatic clear_log();
        bytes.delete();
        stuff_cnt = 0;
        align_cnt = 0;
    endtask

    task automatic send_bit(input bit b);
        bus.bit_valid   = 1'b1;
        bus.decoded_bit = b;
        @(posedge clk);
        @(negedge clk);
        bus.bit_valid   = 1'b0;
        bus.decoded_bit = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_bit(seq[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic end_packet();
        bus.packet_active = 1'b0;
        idle(3);
    endtask

    initial begin
        nRST              = 1'b0;
        bus.bit_valid     = 1'b0;
        bus.decoded_bit   = 1'b0;
        bus.packet_active = 1'b0;
        idle(2);
        check("rst_byte_out", bus.byte_out, 8'h00);
        check("rst_byte_valid", bus.byte_valid, 1'b0);
        check("rst_stuff_err", bus.stuff_err, 1'b0);
        check("rst_align_err", bus.align_err, 1'b0);
        nRST = 1'b1;
        idle(2);

        // clean packet: SYNC then 0xA5
        clear_log();
        bus.packet_active = 1'b1;
        seq = '{0, 0, 0, 0, 0, 0, 0, 1};
        send_seq();
        check("sync_valid_latency", bus.byte_valid, 1'b1);
        check("sync_byte_out", bus.byte_out, USB_SYNC_BYTE);
        seq = '{1, 0, 1, 0, 0, 1, 0, 1};
        send_seq();
        end_packet();
        check("clean_count", bytes.size(), 2);
        check("clean_byte1", byte_at(1), 8'hA5);
        check("clean_stuff_err", stuff_cnt, 0);
        check("clean_align_err", align_cnt, 0);

        // two 0xFF bytes; SYNC's final 1 counts toward the first run
        clear_log();
        bus.packet_active = 1'b1;
        seq = '{0, 0, 0, 0, 0, 0, 0, 1,
                1, 1, 1, 1, 1, 0, 1, 1, 1,
                1, 1, 1, 0, 1, 1, 1, 1, 1};
        send_seq();
        end_packet();
        check("stuff_count", bytes.size(), 3);
        check("stuff_byte1", byte_at(1), 8'hFF);
        check("stuff_byte2", byte_at(2), 8'hFF);
        check("stuff_no_err", stuff_cnt, 0);
        check("stuff_no_align", align_cnt, 0);

        // 0xFC ends with six 1s; stuff bit falls right on the byte boundary
        clear_log();
        bus.packet_active = 1'b1;
        seq = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        send_seq();
        check("bnd_valid_before_stuff", bus.byte_valid, 1'b1);
        check("bnd_byte_out", bus.byte_out, 8'hFC);
        seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        send_seq();
        end_packet();
        check("bnd_count", bytes.size(), 3);
        check("bnd_next_byte", byte_at(2), 8'h55);
        check("bnd_no_err", stuff_cnt + align_cnt, 0);

        // violation: seven consecutive 1s
        clear_log();
        bus.packet_active = 1'b1;
        seq = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
        send_seq();
        check("viol_not_yet", bus.stuff_err, 1'b0);
        send_bit(1'b1);
        check("viol_pulse", bus.stuff_err, 1'b1);
        seq = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 0};
        send_seq();
        end_packet();
        check("viol_bytes", bytes.size(), 1);
        check("viol_pulses", stuff_cnt, 1);
        check("viol_no_align", align_cnt, 0);
        bus.packet_active = 1'b1;
        seq = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0};
        send_seq();
        end_packet();
        check("viol_recover_count", bytes.size(), 3);
        check("viol_recover_sync", byte_at(1), 8'h80);
        check("viol_recover_byte", byte_at(2), 8'h3C);

        // partial byte at end of packet
        clear_log();
        bus.packet_active = 1'b1;
        seq = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
        send_seq();
        bus.packet_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("partial_align_latency", bus.align_err, 1'b1);
        idle(3);
        check("partial_bytes", bytes.size(), 1);
        check("partial_byte0", byte_at(0), 8'h80);
        check("partial_align_pulses", align_cnt, 1);

        // asynchronous reset mid-packet
        clear_log();
        bus.packet_active = 1'b1;
        seq = '{0, 0, 0, 0};
        send_seq();
        #2;
        nRST = 1'b0;
        #1;
        check("arst_byte_out", bus.byte_out, 8'h00);
        check("arst_outputs", {bus.byte_valid, bus.stuff_err, bus.align_err}, 3'b000);
        bus.packet_active = 1'b0;
        idle(2);
        nRST = 1'b1;
        idle(2);
        bus.packet_active = 1'b1;
        seq = '{0, 0, 0, 0, 0, 0, 0, 1};
        send_seq();
        end_packet();
        check("arst_next_count", bytes.size(), 1);
        check("arst_next_sync", byte_at(0), 8'h80);
        check("arst_no_err", stuff_cnt + align_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
